fir_smpl_queue: RTL and testbench

- Stereo circular sample queue that sits upstream of the FIR band filters and feeds them.
- Stores incoming left/right audio samples.
- Once it holds a full window, it replays the most recent NUM_TAPS sample pairs, oldest first, one pair per clock, with `sequencing` asserted for the FIR accumulators.
- It is the producer end of the `sequencing`/sample interface the FIR bands consume.

---
 rtl/fir_smpl_queue.sv | 123 ++++++++++++
 tb/tb_fir_smpl_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_smpl_queue.sv
// Stereo circular sample queue feeding the FIR bands with replay windows.
// Optional macro SMPL_QUEUE_OVERRUN_EN adds a sticky overrun output.
module fir_smpl_queue #(
   parameter int DEPTH    = 1024,
   parameter int NUM_TAPS = 1021,
   parameter int PTR_W    = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrt_smpl,
   input  logic [15:0] lft_smpl,
   input  logic [15:0] rght_smpl,
   output logic        sequencing,
   output logic [15:0] lft_out,
   output logic [15:0] rght_out
`ifdef SMPL_QUEUE_OVERRUN_EN
   ,
   output logic        overrun
`endif
);

   localparam int CNT_W = $clog2(NUM_TAPS + 1);
   localparam logic [PTR_W-1:0] BACK = PTR_W'(NUM_TAPS - 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TAPS - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_TAPS);

   typedef enum logic [1:0] {FILL, IDLE, SEQ} state_t;

   logic [15:0]      lft_mem  [DEPTH];
   logic [15:0]      rght_mem [DEPTH];
   state_t           state;
   logic [PTR_W-1:0] new_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] pend_ptr;
   logic [CNT_W-1:0] fill_cnt;
   logic [CNT_W-1:0] tap_cnt;
   logic             pending;
   logic             bubble;
   logic             rd_en;
   logic             last_rd;
   logic             start;

   assign rd_en   = (state == SEQ) && !bubble;
   assign last_rd = rd_en && (tap_cnt == LAST);
   assign start   = wrt_smpl &&
                    ((state == IDLE) ||
                     ((state == FILL) && (fill_cnt == LAST)));

   always_ff @(posedge clk) begin
      if (wrt_smpl && !rst) begin
         lft_mem[new_ptr]  <= lft_smpl;
         rght_mem[new_ptr] <= rght_smpl;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         new_ptr    <= '0;
         rd_ptr     <= '0;
         pend_ptr   <= '0;
         fill_cnt   <= '0;
         tap_cnt    <= '0;
         pending    <= 1'b0;
         bubble     <= 1'b0;
         sequencing <= 1'b0;
         lft_out    <= '0;
         rght_out   <= '0;
      end else begin
         sequencing <= rd_en;
         if (wrt_smpl) begin
            new_ptr <= new_ptr + 1'b1;
            if (fill_cnt != FULL)
               fill_cnt <= fill_cnt + 1'b1;
         end
         if (rd_en) begin
            lft_out  <= lft_mem[rd_ptr];
            rght_out <= rght_mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
            tap_cnt  <= tap_cnt + 1'b1;
         end
         unique case (state)
            FILL, IDLE: begin
               if (start) begin
                  state   <= SEQ;
                  rd_ptr  <= new_ptr - BACK;
                  tap_cnt <= '0;
                  bubble  <= 1'b0;
               end
            end
            SEQ: begin
               if (bubble)
                  bubble <= 1'b0;
               if (last_rd) begin
                  pending <= 1'b0;
                  // restart after one idle output cycle so FIR bands rearm
                  if (pending || wrt_smpl) begin
                     bubble  <= 1'b1;
                     tap_cnt <= '0;
                     rd_ptr  <= (pending ? pend_ptr : new_ptr) - BACK;
                  end else begin
                     state <= IDLE;
                  end
               end else if (wrt_smpl && !pending) begin
                  pending  <= 1'b1;
                  pend_ptr <= new_ptr;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

`ifdef SMPL_QUEUE_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (rst)
         overrun <= 1'b0;
      else if ((state == SEQ) && wrt_smpl && pending)
         overrun <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_fir_smpl_queue.sv
// Randomized and directed bench for fir_smpl_queue against a write-history
// model of replay windows (DEPTH=16, NUM_TAPS=13).
module tb_fir_smpl_queue;

   localparam int D    = 16;
   localparam int N    = 13;
   localparam int MAXC = 4000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wrt_smpl = 1'b0;
   logic [15:0] lft_smpl = '0;
   logic [15:0] rght_smpl = '0;
   logic        sequencing;
   logic [15:0] lft_out;
   logic [15:0] rght_out;
`ifdef SMPL_QUEUE_OVERRUN_EN
   logic        overrun;
`endif

   fir_smpl_queue #(.DEPTH(D), .NUM_TAPS(N), .PTR_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .wrt_smpl(wrt_smpl),
      .lft_smpl(lft_smpl),
      .rght_smpl(rght_smpl),
      .sequencing(sequencing),
      .lft_out(lft_out),
      .rght_out(rght_out)
`ifdef SMPL_QUEUE_OVERRUN_EN
      ,
      .overrun(overrun)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = -1;

   bit          exp_seq [MAXC];
   logic [15:0] exp_l   [MAXC];
   logic [15:0] exp_r   [MAXC];
   logic [15:0] hl[$];
   logic [15:0] hr[$];
   logic [15:0] last_l = '0;
   logic [15:0] last_r = '0;
   int fill = 0;
   int busy_s = -100;
   int busy_e = -100;
   bit pend = 0;
   int pend_w = 0;
   bit ovr = 0;
   int w1 = -1000, w2 = -1000, w3 = -1000;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic sched(input int c, input int w);
      for (int k = 0; k < N; k++) begin
         if (c + 2 + k < MAXC) begin
            exp_seq[c+2+k] = 1'b1;
            exp_l[c+2+k]   = hl[w-(N-1)+k];
            exp_r[c+2+k]   = hr[w-(N-1)+k];
         end
      end
   endtask

   task automatic model(input int c, input bit wr, input logic [15:0] l,
                        input logic [15:0] r, input bit rs);
      int w;
      if (rs) begin
         hl.delete();
         hr.delete();
         fill = 0;
         pend = 0;
         busy_s = -100;
         busy_e = -100;
         ovr = 0;
         last_l = '0;
         last_r = '0;
         for (int i = c + 1; i < c + 41 && i < MAXC; i++)
            exp_seq[i] = 1'b0;
         return;
      end
      if (pend && c == busy_e + 1) begin
         sched(c, pend_w);
         busy_s = c;
         busy_e = c + N;
         pend = 0;
      end
      if (wr) begin
         hl.push_back(l);
         hr.push_back(r);
         w = hl.size() - 1;
         if (fill < N) fill++;
         if (c >= busy_s && c <= busy_e) begin
            if (!pend) begin
               pend = 1;
               pend_w = w;
            end else begin
               ovr = 1;
            end
         end else if (fill == N) begin
            sched(c, w);
            busy_s = c + 1;
            busy_e = c + N;
         end
      end
   endtask

   task automatic tick(input bit wr, input logic [15:0] l,
                       input logic [15:0] r, input bit rs);
      @(posedge clk);
      #1;
      cyc++;
      rst = rs;
      wrt_smpl = wr;
      lft_smpl = l;
      rght_smpl = r;
      if (wr) begin
         w3 = w2;
         w2 = w1;
         w1 = cyc;
      end
      @(negedge clk);
      if (exp_seq[cyc]) begin
         last_l = exp_l[cyc];
         last_r = exp_r[cyc];
      end
      chk("seq", {15'd0, sequencing}, {15'd0, exp_seq[cyc]});
      chk("lft", lft_out, last_l);
      chk("rght", rght_out, last_r);
`ifdef SMPL_QUEUE_OVERRUN_EN
      chk("ovr", {15'd0, overrun}, {15'd0, ovr});
`endif
      model(cyc, wr, l, r, rs);
   endtask

   task automatic wr_pair(input int v);
      tick(1'b1, 16'(v), 16'(-v), 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      bit wr, rs;
      tick(1'b0, '0, '0, 1'b1);
      tick(1'b0, '0, '0, 1'b1);
      idle(2);
      for (int v = 1; v <= 12; v++) begin
         wr_pair(v);
         idle(1);
      end
      wr_pair(13);
      idle(20);
      for (int v = 14; v <= 20; v++) begin
         wr_pair(v);
         idle(20);
      end
      wr_pair(21);
      idle(5);
      wr_pair(22);
      idle(40);
      wr_pair(23);
      idle(2);
      wr_pair(24);
      idle(1);
      wr_pair(25);
      idle(1);
      wr_pair(26);
      idle(40);
      wr_pair(27);
      idle(6);
      tick(1'b0, '0, '0, 1'b1);
      idle(2);
      for (int v = 100; v < 112; v++) begin
         wr_pair(v);
         idle(2);
      end
      idle(30);
      wr_pair(112);
      idle(45);
      for (int i = 0; i < 1500; i++) begin
         rs = ($urandom_range(0, 599) == 0);
         wr = !rs && ($urandom_range(0, 4) == 0) && (cyc + 1 - w3 > 40);
         tick(wr, 16'($urandom), 16'($urandom), rs);
      end
      idle(40);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
